// File: rtl/pulse_gen.sv
// pulse_gen: readout-pulse synthesizer. Produces a phase-coherent,
// amplitude-scaled I/Q carrier, five lanes per clk100 cycle, through a
// three-stage pipeline (phase, sine lookup, multiply).
module pulse_gen #(
  parameter int LANES = 5,
  parameter int DW    = 16,
  parameter int PW    = 14
) (
  input  logic                  clk100,
  input  logic                  reset,
  input  logic                  start,
  input  logic [3:0]            mod_freq,
  input  logic [10:0]           pulse_length,
  input  logic [15:0]           amplitude,
  output logic [LANES*DW-1:0]   data_i_out,
  output logic [LANES*DW-1:0]   data_q_out,
  output logic [LANES*PW-1:0]   phase_vals,
  output logic                  valid,
  output logic                  busy,
  output logic                  sample_start,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, PLAY, DRAIN, DONE} state_t;

  state_t state, state_next;

  logic          capture;
  logic          issue;
  logic [PW-1:0] inc_in;
  logic [14:0]   amp_sat;

  logic [PW-1:0] inc_q;
  logic [PW-1:0] acc_q;
  logic [10:0]   len_q;
  logic [10:0]   cnt_q;
  logic [14:0]   amp_q;
  logic [1:0]    drain_cnt_q;

  logic                 s1_valid, s1_first;
  logic [PW-1:0]        s1_phase [LANES];
  logic                 s2_valid, s2_first;
  logic [PW-1:0]        s2_phase [LANES];
  logic signed [DW-1:0] s2_sin   [LANES];
  logic signed [DW-1:0] s2_cos   [LANES];

  logic signed [DW-1:0] sin_lut [256];

  // Quarter-wave-free full sine table, one entry per 1/256 of a carrier cycle.
  for (genvar n = 0; n < 256; n++) begin : g_lut
    localparam real ANGLE = 2.0 * 3.14159265358979323846 * n / 256.0;
    localparam int  VALUE = int'(32767.0 * $sin(ANGLE));
    assign sin_lut[n] = DW'(VALUE);
  end

  // Per-sample increment and the saturated envelope, computed from the live inputs
  // so they can be latched on the capture edge.
  assign inc_in  = PW'(mod_freq) * PW'(328);
  assign amp_sat = amplitude[15] ? 15'h7FFF : amplitude[14:0];

  // Scale one table value by the envelope; arithmetic shift floors toward -inf.
  function automatic logic [DW-1:0] scale(input logic [14:0] amp,
                                          input logic signed [DW-1:0] t);
    logic signed [2*DW:0] p;
    p = $signed({{(DW+2){1'b0}}, amp}) * $signed({{(DW+1){t[DW-1]}}, t});
    return DW'(p >>> (DW - 1));
  endfunction

  // State register.
  always_ff @(posedge clk100 or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic plus the control strobes and status outputs decoded from state.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    issue      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          capture    = 1'b1;
          state_next = (pulse_length == 11'd0) ? DONE : PLAY;
        end
      end
      PLAY: begin
        issue = 1'b1;
        busy  = 1'b1;
        if (cnt_q == len_q - 11'd1) state_next = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_cnt_q == 2'd2) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Pulse parameters are frozen at capture; the accumulator and group counter
  // advance once per issued lane-group.
  always_ff @(posedge clk100 or negedge reset) begin
    if (!reset) begin
      inc_q       <= '0;
      acc_q       <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      amp_q       <= '0;
      drain_cnt_q <= '0;
    end else begin
      if (capture) begin
        inc_q <= inc_in;
        len_q <= pulse_length;
        amp_q <= amp_sat;
        acc_q <= '0;
        cnt_q <= '0;
      end else if (issue) begin
        acc_q <= acc_q + (inc_q << 2) + inc_q;
        cnt_q <= cnt_q + 11'd1;
      end
      if (state == DRAIN) drain_cnt_q <= drain_cnt_q + 2'd1;
      else                drain_cnt_q <= '0;
    end
  end

  // Stage 1: per-lane phase of the group being issued.
  always_ff @(posedge clk100 or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      for (int k = 0; k < LANES; k++) s1_phase[k] <= '0;
    end else begin
      s1_valid <= issue;
      s1_first <= issue && (cnt_q == 11'd0);
      for (int k = 0; k < LANES; k++)
        s1_phase[k] <= issue ? acc_q + PW'(k) * inc_q : '0;
    end
  end

  // Stage 2: sine and cosine lookup from the top eight phase bits.
  always_ff @(posedge clk100 or negedge reset) begin
    if (!reset) begin
      s2_valid <= 1'b0;
      s2_first <= 1'b0;
      for (int k = 0; k < LANES; k++) begin
        s2_phase[k] <= '0;
        s2_sin[k]   <= '0;
        s2_cos[k]   <= '0;
      end
    end else begin
      s2_valid <= s1_valid;
      s2_first <= s1_first;
      for (int k = 0; k < LANES; k++) begin
        s2_phase[k] <= s1_phase[k];
        s2_sin[k]   <= sin_lut[s1_phase[k][PW-1 -: 8]];
        s2_cos[k]   <= sin_lut[8'(s1_phase[k][PW-1 -: 8] + 8'd64)];
      end
    end
  end

  // Stage 3: envelope multiply and output registers; lanes are forced to zero
  // whenever no pulse sample is present.
  always_ff @(posedge clk100 or negedge reset) begin
    if (!reset) begin
      valid        <= 1'b0;
      sample_start <= 1'b0;
      data_i_out   <= '0;
      data_q_out   <= '0;
      phase_vals   <= '0;
    end else begin
      valid        <= s2_valid;
      sample_start <= s2_valid && s2_first;
      for (int k = 0; k < LANES; k++) begin
        data_i_out[k*DW +: DW] <= s2_valid ? scale(amp_q, s2_cos[k]) : '0;
        data_q_out[k*DW +: DW] <= s2_valid ? scale(amp_q, s2_sin[k]) : '0;
        phase_vals[k*PW +: PW] <= s2_valid ? s2_phase[k] : '0;
      end
    end
  end

endmodule
